// File: rtl/neocd_mailbox_fifo_pkg.sv
// neocd_mailbox_pkg: status bit map and byte-swap helper for the console<->MCU mailbox (rev 1.0)
`default_nettype none

package neocd_mailbox_pkg;

  localparam int STAT_DATA_PENDING = 0;
  localparam int STAT_EXEC_PENDING = 1;
  localparam int STAT_REFILL_REQ   = 2;
  localparam int STAT_EMPTY        = 3;
  localparam int STAT_FULL         = 4;
  localparam int STAT_OVERFLOW     = 5;
  localparam int STAT_UNDERFLOW    = 6;
  localparam int STAT_CKSUM_EN     = 7;
  localparam int STAT_LEVEL_LSB    = 8;

  localparam int SWAP_MAX_W = 64;

  // Reverses the byte order of the low w bits of d; bits above w come back as zero.
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                      input int w);
    logic [SWAP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SWAP_MAX_W / 8; i++) begin
      if (i < w / 8) r[8*i +: 8] = d[w - 8 - 8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/neocd_mailbox_fifo_if.sv
// neocd_mailbox_fifo_if: console bus + MCU side signals of the mailbox (rev 1.0)
`default_nettype none

interface neocd_mailbox_fifo_if #(
  parameter int DATA_W = 16
);
  import neocd_mailbox_pkg::*;

  logic              CPU_RD;
  logic              CPU_WR;
  logic              CPU_EXEC;
  logic [DATA_W-1:0] CPU_WDATA;
  logic [DATA_W-1:0] CPU_RDATA;
  logic [15:0]       CPU_STATUS;
  logic              MCU_PUSH_TGL;
  logic              MCU_ACK_TGL;
  logic [DATA_W-1:0] MCU_DIN;
  logic [DATA_W-1:0] MCU_DOUT;
  logic              DATA_PENDING;
  logic              EXEC_PENDING;
  logic              REFILL_REQ;
  logic              TRANSFER_TYPE;

  modport slave (
    input  CPU_RD, CPU_WR, CPU_EXEC, CPU_WDATA, MCU_PUSH_TGL, MCU_ACK_TGL, MCU_DIN,
    output CPU_RDATA, CPU_STATUS, MCU_DOUT, DATA_PENDING, EXEC_PENDING, REFILL_REQ,
           TRANSFER_TYPE
  );

  modport master (
    output CPU_RD, CPU_WR, CPU_EXEC, CPU_WDATA, MCU_PUSH_TGL, MCU_ACK_TGL, MCU_DIN,
    input  CPU_RDATA, CPU_STATUS, MCU_DOUT, DATA_PENDING, EXEC_PENDING, REFILL_REQ,
           TRANSFER_TYPE
  );

endinterface

`default_nettype wire

// File: rtl/neocd_mailbox_fifo_toggle_sync.sv
// neocd_toggle_sync: 2-flop synchroniser for an async toggle, one-cycle pulse per toggle edge (rev 1.0)
`default_nettype none

module neocd_toggle_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= tgl_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Pulse is high during the cycle ending in the 3rd edge after the toggle.
  assign pulse_o = sync_q ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/neocd_mailbox_fifo.sv
// neocd_mailbox_fifo: MCU->console FIFO with low-water refill, console->MCU word/EXEC latch (rev 1.0)
// Optional MAILBOX_CKSUM_EN adds a running sum of popped words, readable via CPU_RD with CPU_WDATA[0]=1.
`default_nettype none

module neocd_mailbox_fifo
  import neocd_mailbox_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int LOW_WATER  = 2,
  parameter int SWAP_BYTES = 1
) (
  input logic                 CLK_68KCLK,
  input logic                 nRESET,
  neocd_mailbox_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  function automatic logic [DATA_W-1:0] swap_w(input logic [DATA_W-1:0] d);
    if (SWAP_BYTES != 0) return DATA_W'(byte_swap(SWAP_MAX_W'(d), DATA_W));
    return d;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, dout_q, dout_d;
  logic data_pend_q, data_pend_d, exec_pend_q, exec_pend_d, ttype_q, ttype_d;
  logic ovf_q, ovf_d, unf_q, unf_d, refill_q, refill_d;
  logic w_push_pulse, w_ack_pulse, w_empty, w_full, w_rd, w_cksum_rd, w_push_ok, w_pop;
  logic [DATA_W-1:0] w_head;
  logic [15:0]       w_status;
`ifdef MAILBOX_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
`endif

  neocd_toggle_sync u_push_sync (
    .clk_i(CLK_68KCLK), .rst_ni(nRESET), .tgl_i(bus.MCU_PUSH_TGL), .pulse_o(w_push_pulse)
  );
  neocd_toggle_sync u_ack_sync (
    .clk_i(CLK_68KCLK), .rst_ni(nRESET), .tgl_i(bus.MCU_ACK_TGL), .pulse_o(w_ack_pulse)
  );

  assign w_head  = mem_q[rd_ptr_q];
  assign w_empty = (level_q == '0);
  assign w_full  = (level_q == LVL_W'(DEPTH));
`ifdef MAILBOX_CKSUM_EN
  assign w_cksum_rd = bus.CPU_RD & bus.CPU_WDATA[0];
`else
  assign w_cksum_rd = 1'b0;
`endif
  assign w_rd      = bus.CPU_RD & ~w_cksum_rd;
  assign w_pop     = w_rd & ~w_empty & ~bus.CPU_EXEC;
  // A push into a full FIFO still fits when the same edge pops a word.
  assign w_push_ok = w_push_pulse & ~bus.CPU_EXEC & (~w_full | w_pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rdata_d     = rdata_q;
    dout_d      = dout_q;
    data_pend_d = data_pend_q;
    exec_pend_d = exec_pend_q;
    ttype_d     = ttype_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    refill_d    = (level_q <= LVL_W'(LOW_WATER));
`ifdef MAILBOX_CKSUM_EN
    cksum_d     = cksum_q;
`endif
    if (w_ack_pulse) begin
      data_pend_d = 1'b0;
      exec_pend_d = 1'b0;
    end
    if (bus.CPU_EXEC) begin
      rd_ptr_d    = wr_ptr_q;
      level_d     = '0;
      exec_pend_d = 1'b1;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
`ifdef MAILBOX_CKSUM_EN
      cksum_d     = '0;
`endif
    end else begin
      if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_push_pulse && !w_push_ok) ovf_d = 1'b1;
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rdata_d  = swap_w(w_head);
`ifdef MAILBOX_CKSUM_EN
        cksum_d  = cksum_q + 16'(w_head);
`endif
      end
      if (w_rd && w_empty) unf_d = 1'b1;
      if (bus.CPU_RD) ttype_d = 1'b0;
`ifdef MAILBOX_CKSUM_EN
      if (w_cksum_rd) rdata_d = DATA_W'(cksum_q);
`endif
      level_d = level_q + LVL_W'(w_push_ok) - LVL_W'(w_pop);
    end
    if (bus.CPU_WR) begin
      dout_d      = swap_w(bus.CPU_WDATA);
      data_pend_d = 1'b1;
      ttype_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= bus.MCU_DIN;
  end

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      data_pend_q <= 1'b0;
      exec_pend_q <= 1'b0;
      ttype_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      refill_q    <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      data_pend_q <= data_pend_d;
      exec_pend_q <= exec_pend_d;
      ttype_q     <= ttype_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      refill_q    <= refill_d;
    end
  end

`ifdef MAILBOX_CKSUM_EN
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) cksum_q <= '0;
    else         cksum_q <= cksum_d;
  end
`endif

  always_comb begin
    w_status                    = '0;
    w_status[STAT_DATA_PENDING] = data_pend_q;
    w_status[STAT_EXEC_PENDING] = exec_pend_q;
    w_status[STAT_REFILL_REQ]   = refill_q;
    w_status[STAT_EMPTY]        = w_empty;
    w_status[STAT_FULL]         = w_full;
    w_status[STAT_OVERFLOW]     = ovf_q;
    w_status[STAT_UNDERFLOW]    = unf_q;
`ifdef MAILBOX_CKSUM_EN
    w_status[STAT_CKSUM_EN]     = 1'b1;
`endif
    w_status[STAT_LEVEL_LSB +: 8] = 8'(level_q);
  end

  assign bus.CPU_RDATA     = rdata_q;
  assign bus.CPU_STATUS    = w_status;
  assign bus.MCU_DOUT      = dout_q;
  assign bus.DATA_PENDING  = data_pend_q;
  assign bus.EXEC_PENDING  = exec_pend_q;
  assign bus.REFILL_REQ    = refill_q;
  assign bus.TRANSFER_TYPE = ttype_q;

endmodule

`default_nettype wire
